// File: rtl/conv_encoder_tx_if.sv
// rtl/conv_encoder_tx_if.sv - byte input stream and coded symbol stream of the convolutional encoder
interface conv_encoder_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [1:0]        sym_out;
    logic              sym_valid;
    logic              sym_ready;
    logic              sym_last;

    modport master (
        output in_data, in_valid, in_last, sym_ready,
        input  in_ready, sym_out, sym_valid, sym_last
    );

    modport slave (
        input  in_data, in_valid, in_last, sym_ready,
        output in_ready, sym_out, sym_valid, sym_last
    );
endinterface

// File: rtl/conv_encoder_tx.sv
// rtl/conv_encoder_tx.sv - rate-1/2 K=3 (7,5) convolutional encoder, MSB-first, zero-tail terminated frames
module conv_encoder_tx #(
    parameter int DATA_W   = 8,
    parameter int TAIL_LEN = 2
) (
    input  logic                clk,
    input  logic                rst,
    conv_encoder_tx_if.slave    bus,
    output logic                busy
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
    localparam logic [CW-1:0] BIT_MAX  = CW'(DATA_W - 1);
    localparam logic [TW-1:0] TAIL_MAX = TW'(TAIL_LEN - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] shreg, shreg_nx;
    logic [CW-1:0]     bit_cnt, bit_cnt_nx;
    logic [TW-1:0]     tail_cnt, tail_cnt_nx;
    logic              last_q, last_q_nx;
    logic [1:0]        enc_s, enc_s_nx;
    logic [1:0]        sym_out_q;
    logic              sym_valid_q, sym_last_q;

    logic              adv, gen, gen_last, u, in_ready_c;
    logic              c0, c1;

    assign adv = !sym_valid_q || bus.sym_ready;
    assign c0  = u ^ enc_s[1] ^ enc_s[0];
    assign c1  = u ^ enc_s[0];

    always_comb begin
        state_nx    = state;
        shreg_nx    = shreg;
        bit_cnt_nx  = bit_cnt;
        tail_cnt_nx = tail_cnt;
        last_q_nx   = last_q;
        in_ready_c  = 1'b0;
        gen         = 1'b0;
        gen_last    = 1'b0;
        u           = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    shreg_nx   = bus.in_data;
                    last_q_nx  = bus.in_last;
                    bit_cnt_nx = '0;
                    state_nx   = SHIFT;
                end
            end
            SHIFT: begin
                u = shreg[DATA_W-1];
                if (adv) begin
                    gen        = 1'b1;
                    shreg_nx   = shreg << 1;
                    bit_cnt_nx = bit_cnt + CW'(1);
                    if (bit_cnt == BIT_MAX) begin
                        if (last_q) begin
                            tail_cnt_nx = '0;
                            state_nx    = TAIL;
                        end else begin
                            // Word boundary inside a frame: accept the next word without a bubble.
                            in_ready_c = 1'b1;
                            if (bus.in_valid) begin
                                shreg_nx   = bus.in_data;
                                last_q_nx  = bus.in_last;
                                bit_cnt_nx = '0;
                            end else begin
                                state_nx = IDLE;
                            end
                        end
                    end
                end
            end
            TAIL: begin
                if (adv) begin
                    gen         = 1'b1;
                    tail_cnt_nx = tail_cnt + TW'(1);
                    if (tail_cnt == TAIL_MAX) begin
                        gen_last = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        enc_s_nx = enc_s;
        if (gen) begin
            enc_s_nx = gen_last ? 2'b00 : {u, enc_s[1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            tail_cnt <= '0;
            last_q   <= 1'b0;
            enc_s    <= 2'b00;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            bit_cnt  <= bit_cnt_nx;
            tail_cnt <= tail_cnt_nx;
            last_q   <= last_q_nx;
            enc_s    <= enc_s_nx;
        end
    end

    // Output slot only moves when empty or being consumed, so a stalled symbol holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_out_q   <= 2'b00;
            sym_valid_q <= 1'b0;
            sym_last_q  <= 1'b0;
        end else if (adv) begin
            sym_valid_q <= gen;
            if (gen) begin
                sym_out_q  <= {c0, c1};
                sym_last_q <= gen_last;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.sym_out   = sym_out_q;
    assign bus.sym_valid = sym_valid_q;
    assign bus.sym_last  = sym_last_q;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb/tb_conv_encoder_tx.sv - directed-vector bench for conv_encoder_tx
module tb_conv_encoder_tx;
    logic clk = 1'b0;
    logic rst;
    logic busy;
    bit   rand_mode = 1'b0;

    always #5 clk = ~clk;

    conv_encoder_tx_if #(.DATA_W(8)) bus ();

    conv_encoder_tx #(.DATA_W(8), .TAIL_LEN(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [1:0] cap_sym[$];
    bit         cap_last[$];
    int         cap_cyc[$];
    int         cyc = 0;
    int         busy_cyc = 0;
    int         busy_rdy = 0;
    bit         stall_q = 1'b0;
    logic [1:0] out_q;
    logic       lst_q;

    always @(posedge clk) begin
        #1;
        bus.sym_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        cyc++;
        if (busy) busy_cyc++;
        if (busy && bus.in_ready) busy_rdy++;
        if (stall_q) begin
            check("hold_valid", 32'(bus.sym_valid), 32'd1);
            check("hold_sym", 32'(bus.sym_out), 32'(out_q));
            check("hold_last", 32'(bus.sym_last), 32'(lst_q));
        end
        stall_q = bus.sym_valid && !bus.sym_ready && !rst;
        out_q   = bus.sym_out;
        lst_q   = bus.sym_last;
        if (bus.sym_valid && bus.sym_ready) begin
            cap_sym.push_back(bus.sym_out);
            cap_last.push_back(bus.sym_last);
            cap_cyc.push_back(cyc);
        end
    end

    task automatic clear_cap();
        cap_sym.delete();
        cap_last.delete();
        cap_cyc.delete();
        busy_cyc = 0;
        busy_rdy = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_count(input int n);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            if (cap_sym.size() >= n) return;
        end
        check("wait_timeout", 32'(cap_sym.size()), 32'(n));
    endtask

    task automatic check_seq(input string tag, input logic [1:0] exp[$]);
        int n;
        check({tag, "_count"}, 32'(cap_sym.size()), 32'(exp.size()));
        n = (cap_sym.size() < exp.size()) ? cap_sym.size() : exp.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_sym%0d", tag, i), 32'(cap_sym[i]), 32'(exp[i]));
            check($sformatf("%s_last%0d", tag, i), 32'(cap_last[i]), 32'(i == exp.size() - 1));
        end
    endtask

    logic [1:0] exp_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.sym_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sym_valid", 32'(bus.sym_valid), 32'd0);
        check("rst_sym_last", 32'(bus.sym_last), 32'd0);
        check("rst_sym_out", 32'(bus.sym_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single word 0x03, last
        clear_cap();
        send(8'h03, 1'b1);
        bus.in_valid = 1'b0;
        wait_count(10);
        repeat (3) @(posedge clk);
        exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd3};
        check_seq("w03", exp_q);
        check("w03_busy_cycles", 32'(busy_cyc), 32'd10);
        check("w03_ready_while_busy", 32'(busy_rdy), 32'd0);
        check("w03_idle_ready", 32'(bus.in_ready), 32'd1);

        // Two words back to back, state carried
        #1;
        clear_cap();
        send(8'h03, 1'b0);
        send(8'hB0, 1'b1);
        bus.in_valid = 1'b0;
        wait_count(18);
        repeat (3) @(posedge clk);
        exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1,
                  2'd2, 2'd1, 2'd0, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        check_seq("two", exp_q);
        if (cap_cyc.size() == 18) check("two_no_gap", 32'(cap_cyc[17] - cap_cyc[0]), 32'd17);

        // 0xB0 under random backpressure
        #1;
        clear_cap();
        rand_mode = 1'b1;
        send(8'hB0, 1'b1);
        bus.in_valid = 1'b0;
        wait_count(10);
        rand_mode = 1'b0;
        repeat (4) @(posedge clk);
        exp_q = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        check_seq("bp", exp_q);

        // Spurious in_valid pulse during SHIFT is ignored
        #1;
        clear_cap();
        send(8'h03, 1'b1);
        bus.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus.in_data  = 8'hFF;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_count(10);
        repeat (4) @(posedge clk);
        exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd3};
        check_seq("ign", exp_q);
        check("ign_busy_cycles", 32'(busy_cyc), 32'd10);
        check("ign_busy_after", 32'(busy), 32'd0);

        // Reset mid-frame
        #1;
        clear_cap();
        send(8'hB0, 1'b1);
        bus.in_valid = 1'b0;
        wait_count(4);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mrst_sym_valid", 32'(bus.sym_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_cap();
        send(8'hB0, 1'b1);
        bus.in_valid = 1'b0;
        wait_count(10);
        repeat (3) @(posedge clk);
        exp_q = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        check_seq("mrst", exp_q);

        // Idle gap inside a frame keeps encoder state
        #1;
        clear_cap();
        send(8'h03, 1'b0);
        bus.in_valid = 1'b0;
        wait_count(8);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("gap_valid%0d", i), 32'(bus.sym_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(8'hB0, 1'b1);
        bus.in_valid = 1'b0;
        wait_count(18);
        repeat (3) @(posedge clk);
        exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1,
                  2'd2, 2'd1, 2'd0, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        check_seq("gap", exp_q);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
